// File: rtl/pwm_cmd_pkg.sv
// Shared definitions for the PWM command driver: command word layout, opcodes
// and the duty clamp used by the decoder.
package pwm_cmd_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_MSB = 15;
  localparam int unsigned CH_LSB = 14;
  localparam int unsigned OP_MSB = 13;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned ARG_W  = 12;
  // One extra bit so a duty of exactly PERIOD (up to 4096) is representable.
  localparam int unsigned DUTY_W = ARG_W + 1;

  typedef enum logic [1:0] {
    OP_SET_DUTY = 2'b00,
    OP_SET_DIR  = 2'b01,
    OP_STOP_ALL = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [ARG_W-1:0]  arg,
                                                   input logic [DUTY_W-1:0] period);
    logic [DUTY_W-1:0] a;
    a = {1'b0, arg};
    return (a > period) ? period : a;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair with boundary load, global clear,
// and a registered compare against the shared period counter.
module pwm_channel
  import pwm_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              set_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] cnt_i,
  output logic              pwm_o
);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pwm_q, pwm_d;

  // Clear overrides both the boundary load and a same-cycle shadow write.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (load_i) active_d = shadow_q;
    if (set_i)  shadow_d = duty_i;
    if (clear_i) begin
      shadow_d = '0;
      active_d = '0;
    end
    pwm_d = (cnt_i < active_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_cmd_driver.sv
// Command-word driven 4-channel PWM generator: handshake/decode, prescaler,
// period counter and command watchdog; per-channel duty logic lives in pwm_channel.
module pwm_cmd_driver
  import pwm_cmd_pkg::*;
#(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned PERIOD   = 4000,
  parameter int unsigned TIMEOUT  = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_rdy,
  output logic [3:0]  pwm_out,
  output logic [3:0]  dir_out,
  output logic        timeout_flag
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD);
  localparam logic [WW-1:0]     WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0]     WD_MAX   = WW'(TIMEOUT);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              flag_q, flag_d;
  logic [3:0]        dir_q, dir_d;
  logic              rdy_q, rdy_d;

  logic              accept, tick, wrap, trip, clear_all;
  op_e               op;
  logic [1:0]        ch;
  logic [ARG_W-1:0]  arg;
  logic [DUTY_W-1:0] duty_arg;
  logic [NUM_CH-1:0] set_duty;

  always_comb begin
    accept    = cmd_valid & rdy_q;
    op        = op_e'(cmd_data[OP_MSB:OP_LSB]);
    ch        = cmd_data[CH_MSB:CH_LSB];
    arg       = cmd_data[ARG_W-1:0];
    duty_arg  = clamp_duty(arg, PERIOD_D);
    tick      = (presc_q == PRE_LAST);
    wrap      = tick && (cnt_q == CNT_LAST);
    // An accept in the trip cycle suppresses the trip.
    trip      = !accept && (wd_q == WD_LAST);
    clear_all = trip || (accept && op == OP_STOP_ALL);

    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;

    wd_d   = accept ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + 1'b1);
    flag_d = accept ? 1'b0 : (trip ? 1'b1 : flag_q);

    dir_d = dir_q;
    if (accept && op == OP_SET_DIR) dir_d[ch] = arg[0];

    set_duty = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      set_duty[i] = accept && (op == OP_SET_DUTY) && (ch == 2'(i));
    end

    rdy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      flag_q  <= 1'b0;
      dir_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      flag_q  <= flag_d;
      dir_q   <= dir_d;
      rdy_q   <= rdy_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk     (clk),
      .rst     (rst),
      .load_i  (wrap),
      .clear_i (clear_all),
      .set_i   (set_duty[g]),
      .duty_i  (duty_arg),
      .cnt_i   (cnt_q),
      .pwm_o   (pwm_out[g])
    );
  end

  assign cmd_rdy      = rdy_q;
  assign dir_out      = dir_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_pwm_cmd_driver.sv
// Bench for pwm_cmd_driver: directed scenarios plus randomized command traffic,
// checked against a cycle-count based behavioural model.
module tb_pwm_cmd_driver;

  localparam int P = 10;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rdy;
  logic [3:0]  pwm_out, dir_out;
  logic        timeout_flag;

  int checks = 0;
  int errors = 0;

  // Model: m_k = clock edges since reset released, so the period phase is m_k % P
  // and the watchdog age is m_k - m_last.
  int       m_k, m_last;
  int       m_shadow[4], m_active[4];
  logic [3:0] m_pwm, m_dir;
  logic     m_flag, m_rdy;

  pwm_cmd_driver #(.PRESCALE(1), .PERIOD(P), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_rdy(cmd_rdy), .pwm_out(pwm_out), .dir_out(dir_out), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_k = 0; m_last = 0; m_pwm = '0; m_dir = '0; m_flag = 1'b0; m_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d);
    bit acc;
    int ch, op, arg, phase;
    acc = v && m_rdy;
    ch = int'(d[15:14]); op = int'(d[13:12]); arg = int'(d[11:0]);
    phase = m_k % P;
    for (int i = 0; i < 4; i++) m_pwm[i] = (phase < m_active[i]);
    m_k++;
    if (m_k % P == 0) for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
    if (acc) begin
      case (op)
        0: m_shadow[ch] = (arg > P) ? P : arg;
        1: m_dir[ch] = d[0];
        2: for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        default: ;
      endcase
    end
    if (!acc && (m_k - m_last == T)) begin
      m_flag = 1'b1;
      for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    end
    if (acc) begin m_flag = 1'b0; m_last = m_k; end
    m_rdy = 1'b1;
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    cmd_valid = v; cmd_data = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [1:0] c, o;
    logic [11:0] a;
    int r;
    c = 2'($urandom_range(0, 3));
    r = $urandom_range(0, 9);
    o = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
    a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, P + 1));
    return {c, o, a};
  endfunction

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", {pwm_out, dir_out, timeout_flag, cmd_rdy}, 10'b0);
    end
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 16'h0);
      if (i == 0) begin
        checks++;
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rdy_first_edge got %b exp 1", cmd_rdy); end
      end
      checks++;
      if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== {m_pwm, m_dir, m_flag, m_rdy}) begin
        errors++; $display("FAIL reset_idle k=%0d got %b %b %b %b exp %b %b %b %b", m_k,
          pwm_out, dir_out, timeout_flag, cmd_rdy, m_pwm, m_dir, m_flag, m_rdy);
      end
    end
    checks++;
    if ({pwm_out, dir_out, timeout_flag} !== 9'b0) begin
      errors++; $display("FAIL reset_after50 got %b exp 0", {pwm_out, dir_out, timeout_flag});
    end
  endtask

  task automatic test_duty(input logic [15:0] word, input int chan, input int exp_ones, input string tag);
    int ones;
    do_reset();
    step(1'b0, 16'h0);
    step(1'b1, word);
    ones = 0;
    for (int k = 3; k <= 30; k++) begin
      step(1'b0, 16'h0);
      if (k > 10) ones += int'(pwm_out[chan]);
      checks++;
      if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== {m_pwm, m_dir, m_flag, m_rdy}) begin
        errors++; $display("FAIL %s k=%0d got %b %b %b %b exp %b %b %b %b", tag, m_k,
          pwm_out, dir_out, timeout_flag, cmd_rdy, m_pwm, m_dir, m_flag, m_rdy);
      end
    end
    checks++;
    if (ones != exp_ones) begin errors++; $display("FAIL %s_high_count got %0d exp %0d", tag, ones, exp_ones); end
  endtask

  task automatic test_mid_period();
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b0, 16'h0);
    step(1'b1, 16'h8005);
    for (int k = 6; k <= 10; k++) begin
      step(1'b0, 16'h0);
      checks++;
      if (pwm_out !== 4'b0000) begin errors++; $display("FAIL mid_no_partial k=%0d got %b exp 0000", m_k, pwm_out); end
    end
    step(1'b0, 16'h0);
    checks++;
    if (pwm_out !== 4'b0100) begin errors++; $display("FAIL mid_after_wrap got %b exp 0100", pwm_out); end
    step(1'b0, 16'h0);
    step(1'b1, 16'h2000);
    checks++;
    if (pwm_out !== 4'b0100) begin errors++; $display("FAIL stop_accept_edge got %b exp 0100", pwm_out); end
    for (int k = 14; k <= 28; k++) begin
      step(1'b0, 16'h0);
      checks++;
      if (pwm_out !== 4'b0000 || pwm_out !== m_pwm) begin
        errors++; $display("FAIL stop_all k=%0d got %b exp 0000", m_k, pwm_out);
      end
    end
  endtask

  task automatic test_dir_rsvd();
    do_reset();
    step(1'b0, 16'h0);
    step(1'b1, 16'hD001);
    checks++;
    if (dir_out !== 4'b1000) begin errors++; $display("FAIL set_dir got %b exp 1000", dir_out); end
    step(1'b1, 16'h4003);
    step(1'b1, 16'h3000);
    step(1'b1, 16'hF00A);
    checks++;
    if (dir_out !== 4'b1000) begin errors++; $display("FAIL rsvd_dir got %b exp 1000", dir_out); end
    for (int k = 6; k <= 104; k++) begin
      step(1'b0, 16'h0);
      checks++;
      if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== {m_pwm, m_dir, m_flag, m_rdy}) begin
        errors++; $display("FAIL rsvd k=%0d got %b %b %b %b exp %b %b %b %b", m_k,
          pwm_out, dir_out, timeout_flag, cmd_rdy, m_pwm, m_dir, m_flag, m_rdy);
      end
    end
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL rsvd_kick_early got %b exp 0", timeout_flag); end
    step(1'b0, 16'h0);
    checks++;
    if (timeout_flag !== 1'b1) begin errors++; $display("FAIL rsvd_kick_trip got %b exp 1", timeout_flag); end
  endtask

  task automatic test_watchdog();
    int ones;
    do_reset();
    step(1'b0, 16'h0);
    step(1'b1, 16'h0005);
    for (int k = 3; k <= 101; k++) step(1'b0, 16'h0);
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", timeout_flag); end
    step(1'b0, 16'h0);
    checks++;
    if ({timeout_flag, pwm_out[0]} !== 2'b11) begin errors++; $display("FAIL wd_trip got %b exp 11", {timeout_flag, pwm_out[0]}); end
    step(1'b0, 16'h0);
    checks++;
    if (pwm_out !== 4'b0000) begin errors++; $display("FAIL wd_forced_low got %b exp 0000", pwm_out); end
    step(1'b0, 16'h0);
    step(1'b1, 16'h0005);
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp 0", timeout_flag); end
    ones = 0;
    for (int k = 106; k <= 120; k++) begin
      step(1'b0, 16'h0);
      if (k > 110) ones += int'(pwm_out[0]);
      checks++;
      if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== {m_pwm, m_dir, m_flag, m_rdy}) begin
        errors++; $display("FAIL wd_resume k=%0d got %b %b %b %b exp %b %b %b %b", m_k,
          pwm_out, dir_out, timeout_flag, cmd_rdy, m_pwm, m_dir, m_flag, m_rdy);
      end
    end
    checks++;
    if (ones != 5) begin errors++; $display("FAIL wd_resume_count got %0d exp 5", ones); end
  endtask

  task automatic test_random();
    int len, idle;
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      if (seg == 4) begin
        do_reset();
        checks++;
        if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== 10'b0) begin
          errors++; $display("FAIL rand_mid_reset got %b exp 0", {pwm_out, dir_out, timeout_flag, cmd_rdy});
        end
      end
      len  = $urandom_range(20, 60);
      idle = $urandom_range(0, 130);
      for (int i = 0; i < len + idle; i++) begin
        step((i < len) ? 1'($urandom_range(0, 1)) : 1'b0, rand_word());
        checks++;
        if ({pwm_out, dir_out, timeout_flag, cmd_rdy} !== {m_pwm, m_dir, m_flag, m_rdy}) begin
          errors++; $display("FAIL random k=%0d got %b %b %b %b exp %b %b %b %b", m_k,
            pwm_out, dir_out, timeout_flag, cmd_rdy, m_pwm, m_dir, m_flag, m_rdy);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_duty(16'h4003, 1, 6, "set_duty");
    test_duty(16'h0FFF, 0, 20, "clamp");
    test_mid_period();
    test_dir_rsvd();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
